vector_alu_issue: RTL and testbench

Initiator-side sequencer for the lane-parallel vector ALU. It accepts one vector ALU operation per request (operands for all THREADS threads plus an active mask) and drives a physical ALU array of LANES lanes over THREADS/LANES passes. It collects per-thread results and flags and returns them to the writeback stage through a valid/ready handshake. It sits between the issue/operand-read stage and vector register writeback.

---
 rtl/vector_alu_issue.sv | 172 +++++++++++++++++
 tb/tb_vector_alu_issue.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_alu_issue.sv
// Issue sequencer for the lane-parallel vector ALU. It folds THREADS threads onto
// LANES physical lanes over PASSES cycles, skipping empty passes, and returns the collected results.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | ready for a request; an accept latches op/operands/mask
// EXEC  | driving pass pass_q onto the lanes, capturing active threads
// DONE  | response held on rsp_* until rsp_valid & rsp_ready
module vector_alu_issue #(
    parameter int THREADS = 4,
    parameter int LANES   = 2
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [3:0]             req_op,
    input  logic [THREADS*32-1:0]  req_porta,
    input  logic [THREADS*32-1:0]  req_portb,
    input  logic [THREADS-1:0]     req_mask,
    output logic [LANES*4-1:0]     alu_op,
    output logic [LANES*32-1:0]    alu_porta,
    output logic [LANES*32-1:0]    alu_portb,
    input  logic [LANES*32-1:0]    alu_out,
    input  logic [LANES-1:0]       alu_nf,
    input  logic [LANES-1:0]       alu_zf,
    input  logic [LANES-1:0]       alu_of,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [THREADS*32-1:0]  rsp_out,
    output logic [THREADS-1:0]     rsp_wen,
    output logic [THREADS-1:0]     rsp_nmask,
    output logic [THREADS-1:0]     rsp_zmask,
    output logic [THREADS-1:0]     rsp_omask
);

    localparam int PASSES = THREADS / LANES;
    localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           pass_q, pass_d;
    logic [3:0]              op_q;
    logic [THREADS*32-1:0]   porta_q, portb_q, res_q;
    logic [THREADS-1:0]      mask_q, nf_q, zf_q, of_q;

    logic                    idle_found, exec_found;
    logic [PW-1:0]           idle_pass, exec_pass;

    // Lowest-numbered pass with a nonzero mask slice: from 0 for a new request,
    // strictly after the current pass while executing.
    always_comb begin
        idle_found = 1'b0;
        idle_pass  = '0;
        exec_found = 1'b0;
        exec_pass  = '0;
        for (int p = PASSES - 1; p >= 0; p--) begin
            if (req_mask[p*LANES +: LANES] != '0) begin
                idle_found = 1'b1;
                idle_pass  = PW'(p);
            end
            if ((PW'(p) > pass_q) && (mask_q[p*LANES +: LANES] != '0)) begin
                exec_found = 1'b1;
                exec_pass  = PW'(p);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pass_d    = pass_q;
        req_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = nRST;
                if (req_valid) begin
                    pass_d  = idle_pass;
                    state_d = idle_found ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (exec_found) begin
                    pass_d = exec_pass;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane l of pass p carries thread p*LANES+l; masked-off lanes see zero operands.
    always_comb begin
        alu_op    = '0;
        alu_porta = '0;
        alu_portb = '0;
        if (state_q == EXEC) begin
            for (int p = 0; p < PASSES; p++) begin
                if (pass_q == PW'(p)) begin
                    for (int l = 0; l < LANES; l++) begin
                        alu_op[l*4 +: 4] = op_q;
                        if (mask_q[p*LANES + l]) begin
                            alu_porta[l*32 +: 32] = porta_q[(p*LANES + l)*32 +: 32];
                            alu_portb[l*32 +: 32] = portb_q[(p*LANES + l)*32 +: 32];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            op_q    <= '0;
            porta_q <= '0;
            portb_q <= '0;
            mask_q  <= '0;
            res_q   <= '0;
            nf_q    <= '0;
            zf_q    <= '0;
            of_q    <= '0;
        end else if ((state_q == IDLE) && req_valid) begin
            op_q    <= req_op;
            porta_q <= req_porta;
            portb_q <= req_portb;
            mask_q  <= req_mask;
            res_q   <= '0;
            nf_q    <= '0;
            zf_q    <= '0;
            of_q    <= '0;
        end else if (state_q == EXEC) begin
            for (int p = 0; p < PASSES; p++) begin
                for (int l = 0; l < LANES; l++) begin
                    if ((pass_q == PW'(p)) && mask_q[p*LANES + l]) begin
                        res_q[(p*LANES + l)*32 +: 32] <= alu_out[l*32 +: 32];
                        nf_q[p*LANES + l]             <= alu_nf[l];
                        zf_q[p*LANES + l]             <= alu_zf[l];
                        of_q[p*LANES + l]             <= alu_of[l];
                    end
                end
            end
        end
    end

    assign rsp_valid = (state_q == DONE);
    assign rsp_out   = res_q;
    assign rsp_wen   = mask_q;
    assign rsp_nmask = nf_q;
    assign rsp_zmask = zf_q;
    assign rsp_omask = of_q;

endmodule

// File: tb/tb_vector_alu_issue.sv
// Bench for vector_alu_issue: a behavioural ALU array plus a per-operation
// reference (thread results, active pass list, fixed latency) for directed and random requests.
module tb_vector_alu_issue;

    localparam int THREADS = 4;
    localparam int LANES   = 2;
    localparam int PASSES  = THREADS / LANES;
    localparam int TW      = THREADS * 32;

    localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
                           ALU_AND = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
                           ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

    logic                 CLK = 1'b0;
    logic                 nRST;
    logic                 req_valid, req_ready, rsp_valid, rsp_ready;
    logic [3:0]           req_op;
    logic [TW-1:0]        req_porta, req_portb, rsp_out;
    logic [THREADS-1:0]   req_mask, rsp_wen, rsp_nmask, rsp_zmask, rsp_omask;
    logic [LANES*4-1:0]   alu_op;
    logic [LANES*32-1:0]  alu_porta, alu_portb, alu_out;
    logic [LANES-1:0]     alu_nf, alu_zf, alu_of;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    vector_alu_issue #(.THREADS(THREADS), .LANES(LANES)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_porta(req_porta), .req_portb(req_portb), .req_mask(req_mask),
        .alu_op(alu_op), .alu_porta(alu_porta), .alu_portb(alu_portb),
        .alu_out(alu_out), .alu_nf(alu_nf), .alu_zf(alu_zf), .alu_of(alu_of),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
        .rsp_wen(rsp_wen), .rsp_nmask(rsp_nmask), .rsp_zmask(rsp_zmask), .rsp_omask(rsp_omask)
    );

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'd0, a < b};
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic alu_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = alu_f(op, a, b);
        if (op == ALU_ADD) return (a[31] == b[31]) && (s[31] != a[31]);
        if (op == ALU_SUB) return (a[31] != b[31]) && (s[31] != a[31]);
        return 1'b0;
    endfunction

    // Physical ALU array seen by the DUT.
    always_comb begin
        alu_out = '0;
        alu_nf  = '0;
        alu_zf  = '0;
        alu_of  = '0;
        for (int l = 0; l < LANES; l++) begin
            alu_out[l*32 +: 32] = alu_f(alu_op[l*4 +: 4], alu_porta[l*32 +: 32], alu_portb[l*32 +: 32]);
            alu_of[l] = alu_ovf(alu_op[l*4 +: 4], alu_porta[l*32 +: 32], alu_portb[l*32 +: 32]);
            alu_nf[l] = alu_out[l*32 + 31];
            alu_zf[l] = (alu_out[l*32 +: 32] == 32'd0);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_lanes(input string tag);
        chk({tag, "_alu_op"}, alu_op, '0);
        chk({tag, "_alu_porta"}, alu_porta, '0);
        chk({tag, "_alu_portb"}, alu_portb, '0);
    endtask

    task automatic do_op(input logic [3:0] op, input logic [TW-1:0] a, input logic [TW-1:0] b,
                         input logic [THREADS-1:0] mask, input int hold, input logic early,
                         output logic [TW-1:0] g_out, output logic [THREADS-1:0] g_n,
                         output logic [THREADS-1:0] g_z, output logic [THREADS-1:0] g_o);
        logic [TW-1:0]        e_out;
        logic [THREADS-1:0]   e_n, e_z, e_o;
        logic [LANES*32-1:0]  ea, eb;
        int                   ap[$];
        int                   t;
        e_out = '0; e_n = '0; e_z = '0; e_o = '0;
        for (int i = 0; i < THREADS; i++) begin
            if (mask[i]) begin
                e_out[i*32 +: 32] = alu_f(op, a[i*32 +: 32], b[i*32 +: 32]);
                e_o[i] = alu_ovf(op, a[i*32 +: 32], b[i*32 +: 32]);
                e_n[i] = e_out[i*32 + 31];
                e_z[i] = (e_out[i*32 +: 32] == 32'd0);
            end
        end
        ap = {};
        for (int p = 0; p < PASSES; p++)
            if (mask[p*LANES +: LANES] != '0) ap.push_back(p);

        chk("req_ready_before_accept", req_ready, 1'b1);
        chk("rsp_valid_before_accept", rsp_valid, 1'b0);
        req_valid = 1'b1; req_op = op; req_porta = a; req_portb = b; req_mask = mask;
        rsp_ready = early;
        step();
        req_valid = 1'b0;
        req_op = 4'($urandom); req_porta = {4{$urandom}}; req_portb = {4{$urandom}};
        req_mask = THREADS'($urandom);

        foreach (ap[i]) begin
            ea = '0; eb = '0;
            for (int l = 0; l < LANES; l++) begin
                t = ap[i] * LANES + l;
                if (mask[t]) begin
                    ea[l*32 +: 32] = a[t*32 +: 32];
                    eb[l*32 +: 32] = b[t*32 +: 32];
                end
            end
            chk("exec_rsp_valid", rsp_valid, 1'b0);
            chk("exec_req_ready", req_ready, 1'b0);
            chk("exec_alu_op", alu_op, {LANES{op}});
            chk("exec_alu_porta", alu_porta, ea);
            chk("exec_alu_portb", alu_portb, eb);
            step();
        end

        for (int c = 0; c <= hold; c++) begin
            chk("done_rsp_valid", rsp_valid, 1'b1);
            chk("done_rsp_out", rsp_out, e_out);
            chk("done_rsp_wen", rsp_wen, mask);
            chk("done_rsp_nmask", rsp_nmask, e_n);
            chk("done_rsp_zmask", rsp_zmask, e_z);
            chk("done_rsp_omask", rsp_omask, e_o);
            chk("done_req_ready", req_ready, 1'b0);
            chk_idle_lanes("done");
            req_valid = (hold > 0);
            rsp_ready = (c == hold);
            g_out = rsp_out; g_n = rsp_nmask; g_z = rsp_zmask; g_o = rsp_omask;
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("after_hs_rsp_valid", rsp_valid, 1'b0);
        chk("after_hs_req_ready", req_ready, 1'b1);
    endtask

    logic [TW-1:0]       g_out, ra, rb;
    logic [THREADS-1:0]  g_n, g_z, g_o, rm;
    logic [31:0]         edge_vals [4];
    int                  hold;

    initial begin
        edge_vals[0] = 32'h7FFF_FFFF; edge_vals[1] = 32'h8000_0000;
        edge_vals[2] = 32'h0000_0000; edge_vals[3] = 32'hFFFF_FFFF;
        nRST = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_porta = '0; req_portb = '0; req_mask = '0;

        // Reset then idle
        step(); step();
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rsp_out", rsp_out, '0);
        chk("rst_rsp_wen", rsp_wen, '0);
        chk("rst_flags", {rsp_nmask, rsp_zmask, rsp_omask}, '0);
        chk_idle_lanes("rst");
        nRST = 1'b1;
        #1;
        chk("rst_release_req_ready", req_ready, 1'b1);
        step();

        // Full mask ADD with signed overflow on thread 3
        do_op(ALU_ADD, {32'h7FFF_FFFF, 32'd3, 32'd2, 32'd1}, {32'd1, 32'd30, 32'd20, 32'd10},
              4'b1111, 0, 1'b0, g_out, g_n, g_z, g_o);
        chk("add_out_const", g_out, {32'h8000_0000, 32'd33, 32'd22, 32'd11});
        chk("add_omask_const", g_o, 4'b1000);
        chk("add_nmask_const", g_n, 4'b1000);

        // Second pass skipped
        do_op(ALU_SUB, {32'd9, 32'd9, 32'd5, 32'd5}, {32'd0, 32'd0, 32'd1, 32'd5},
              4'b0011, 0, 1'b0, g_out, g_n, g_z, g_o);
        chk("sub_out_const", g_out, {32'd0, 32'd0, 32'd4, 32'd0});
        chk("sub_zmask_const", g_z, 4'b0001);

        // First pass skipped, response taken on DONE entry
        do_op(ALU_XOR, {32'hF0F0_0000, 32'h1234_5678, 32'd7, 32'd7}, {32'h0F0F_0000, 32'h1234_5678, 32'd1, 32'd1},
              4'b1100, 0, 1'b1, g_out, g_n, g_z, g_o);
        chk("xor_out_const", g_out, {32'hFFFF_0000, 32'd0, 32'd0, 32'd0});
        chk("xor_nz_const", {g_n, g_z}, {4'b1000, 4'b0100});

        // Empty mask
        do_op(ALU_ADD, {4{32'hDEAD_BEEF}}, {4{32'h1}}, 4'b0000, 0, 1'b0, g_out, g_n, g_z, g_o);
        chk("empty_out_const", g_out, '0);

        // Backpressure with a competing request held in DONE
        do_op(ALU_OR, {32'd8, 32'd4, 32'd2, 32'd1}, {32'd0, 32'd0, 32'd0, 32'd0},
              4'b1010, 5, 1'b0, g_out, g_n, g_z, g_o);
        chk("bp_out_const", g_out, {32'd8, 32'd0, 32'd2, 32'd0});
        do_op(ALU_SLT, {32'hFFFF_FFFF, 32'd0, 32'd3, 32'd1}, {32'd0, 32'd0, 32'd2, 32'd2},
              4'b1111, 0, 1'b0, g_out, g_n, g_z, g_o);
        chk("slt_out_const", g_out, {32'd1, 32'd0, 32'd0, 32'd1});

        // Reset during EXEC pass 1
        req_valid = 1'b1; req_op = ALU_ADD; req_mask = 4'b1111;
        req_porta = {32'd4, 32'd3, 32'd2, 32'd1}; req_portb = {32'd40, 32'd30, 32'd20, 32'd10};
        step();
        req_valid = 1'b0;
        step();
        chk("midrst_pass1_porta", alu_porta, {32'd4, 32'd3});
        nRST = 1'b0;
        step();
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_req_ready", req_ready, 1'b0);
        chk("midrst_rsp_out", rsp_out, '0);
        chk_idle_lanes("midrst");
        nRST = 1'b1;
        #1;
        chk("midrst_release_req_ready", req_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst_no_rsp", rsp_valid, 1'b0);
            chk("midrst_stays_idle", req_ready, 1'b1);
        end

        // Randomized operations
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < THREADS; i++) begin
                ra[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
                rb[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            end
            rm = THREADS'($urandom);
            hold = $urandom_range(0, 3);
            do_op(4'($urandom_range(0, 9)), ra, rb, rm, hold, (hold == 0) && ($urandom_range(0, 1) == 1),
                  g_out, g_n, g_z, g_o);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
